// File: rtl/fpu_pkg.sv
// Shared definitions for the team float format (1 sign, 6 exponent, 25 mantissa, hidden 1).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fpu_pkg;

  // Exponent bias of the team float format
  localparam int FP_BIAS = 31;

  // Field widths
  localparam int EXP_W  = 6;
  localparam int MANT_W = 25;

  // Field positions inside the 32-bit word
  localparam int SIGN_POS = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 25;
  localparam int MANT_MSB = 24;

  // Result status; OVERFLOW and UNDERFLOW are reserved for the adder and unused by int conversion
  typedef enum logic [1:0] {
    EXACT     = 2'd0,
    INEXACT   = 2'd1,
    OVERFLOW  = 2'd2,
    UNDERFLOW = 2'd3
  } status_t;

endpackage

// File: rtl/int_to_fpu.sv
// Signed 32-bit integer to team float converter, round to nearest / ties to even.
// Latency: N+3 edges from the start-sampling edge to done (N = normalizing shifts), 3 for zero.
// Backpressure: none; start is only sampled in IDLE, starts while busy are dropped.
module int_to_fpu
  import fpu_pkg::*;
#(
  parameter int BIAS = FP_BIAS
) (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] int_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out,
  output logic [3:0]  status_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ABS   = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Exponent of a magnitude whose leading one already sits at bit 31
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(BIAS + 31);

  state_t        r_state;
  logic [31:0]   r_int;
  logic [31:0]   r_mag;
  logic [4:0]    r_cnt;
  logic          r_sign;
  logic          r_zero;
  logic          r_zhold;
  logic          r_busy;
  logic          r_done;
  logic [31:0]   r_data;
  status_t       r_status;

  logic              w_guard;
  logic              w_sticky;
  logic              w_inc;
  logic [MANT_W:0]   w_sum;
  logic [EXP_W-1:0]  w_exp;
  logic [MANT_W-1:0] w_mant;

  // Rounding datapath on the normalized magnitude; carry-out renormalizes to the next binade
  always_comb begin
    w_guard  = r_mag[5];
    w_sticky = |r_mag[4:0];
    w_inc    = w_guard & (w_sticky | r_mag[6]);
    w_sum    = {1'b0, r_mag[30:6]} + {{MANT_W{1'b0}}, w_inc};
    w_exp    = EXP_TOP - {1'b0, r_cnt} + {{(EXP_W-1){1'b0}}, w_sum[MANT_W]};
    w_mant   = w_sum[MANT_W] ? '0 : w_sum[MANT_W-1:0];
  end

  // Conversion FSM with registered outputs
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_int    <= '0;
      r_mag    <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_zero   <= 1'b0;
      r_zhold  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_data   <= '0;
      r_status <= EXACT;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_int   <= int_in;
            r_busy  <= 1'b1;
            r_state <= ABS;
          end
        end
        ABS: begin
          // Negating 0x80000000 wraps back to 0x80000000, which is the correct magnitude
          r_sign  <= r_int[31];
          r_mag   <= r_int[31] ? (~r_int + 32'd1) : r_int;
          r_zero  <= (r_int == 32'd0);
          r_zhold <= 1'b0;
          r_cnt   <= '0;
          r_state <= (r_int == 32'd0) ? ROUND : NORM;
        end
        NORM: begin
          if (r_mag[31]) begin
            r_state <= ROUND;
          end else begin
            r_mag <= r_mag << 1;
            r_cnt <= r_cnt + 5'd1;
          end
        end
        ROUND: begin
          if (r_zero) begin
            // Zero skips NORM; one extra ROUND cycle keeps its latency equal to N=0 operands
            if (!r_zhold) begin
              r_zhold <= 1'b1;
            end else begin
              r_data   <= '0;
              r_status <= EXACT;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end
          end else begin
            r_data[SIGN_POS]        <= r_sign;
            r_data[EXP_MSB:EXP_LSB] <= w_exp;
            r_data[MANT_MSB:0]      <= w_mant;
            r_status <= (w_guard | w_sticky) ? INEXACT : EXACT;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_zhold <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign data_out   = r_data;
  assign status_out = {2'b00, r_status};

endmodule

// File: tb/tb_int_to_fpu.sv
// Directed bench for int_to_fpu: results, status, latency, busy-start rejection, mid-run reset.
module tb_int_to_fpu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] int_in;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  int n_assert = 0;
  int n_fail   = 0;

  int_to_fpu #(.BIAS(31)) dut (
    .clock100KHz (clk),
    .reset       (rst_n),
    .start       (start),
    .int_in      (int_in),
    .busy        (busy),
    .done        (done),
    .data_out    (data_out),
    .status_out  (status_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Issue one conversion and check result, status and start-to-done edge count
  task automatic convert(input string tag, input logic [31:0] v, input logic [31:0] exp_d,
                         input logic [3:0] exp_s, input int exp_lat);
    int lat;
    bit seen;
    @(negedge clk);
    int_in = v;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) seen = 1'b1;
    end
    chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_data"}, data_out, exp_d);
    chk({tag, "_stat"}, {28'd0, status_out}, {28'd0, exp_s});
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hold"}, data_out, exp_d);
  endtask

  initial begin
    int dones;
    rst_n  = 1'b0;
    start  = 1'b0;
    int_in = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_stat", {28'd0, status_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    convert("one",     32'h0000_0001, 32'h3E00_0000, 4'd0, 34);
    convert("neg_one", 32'hFFFF_FFFF, 32'hBE00_0000, 4'd0, 34);
    convert("three",   32'h0000_0003, 32'h4100_0000, 4'd0, 33);
    convert("zero",    32'h0000_0000, 32'h0000_0000, 4'd0, 3);
    convert("min_int", 32'h8000_0000, 32'hFC00_0000, 4'd0, 3);
    convert("max_int", 32'h7FFF_FFFF, 32'h7C00_0000, 4'd1, 4);
    convert("tie_even",32'h4000_0010, 32'h7A00_0000, 4'd1, 4);
    convert("tie_odd", 32'h4000_0030, 32'h7A00_0002, 4'd1, 4);

    // Start pulsed while busy must be dropped: one done, result of the accepted operand only
    @(negedge clk);
    int_in = 32'h0000_0001;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (5) @(negedge clk);
    int_in = 32'h0000_0003;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    int_in = 32'h0000_0000;
    dones  = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        chk("busy_start_data", data_out, 32'h3E00_0000);
      end
    end
    chk("busy_start_dones", dones, 1);
    chk("busy_start_idle", {31'd0, busy}, 32'd0);

    // Reset during NORM: outputs cleared at once, no done, next conversion normal
    @(negedge clk);
    int_in = 32'h0000_0001;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_data", data_out, 32'h0);
    chk("mid_rst_stat", {28'd0, status_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("post_rst_no_done", dones, 0);
    convert("post_rst", 32'h4000_0030, 32'h7A00_0002, 4'd1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global watchdog so the bench can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
